// File: rtl/shared_reg_pkg.sv
// shared_reg_pkg: arbitration mode, writer limit and popcount shared by the arbiter slice
package shared_reg_pkg;
  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
  localparam int MAX_WRITERS = 16;
  function automatic int popcount(input logic [MAX_WRITERS-1:0] v);
    popcount = 0;
    for (int i = 0; i < MAX_WRITERS; i++) popcount += int'(v[i]);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant from the first request at or above the pointer, modulo NUM_WRITERS
module rr_arbiter
  import shared_reg_pkg::*;
#(
  parameter int        NUM_WRITERS = 2,
  parameter arb_mode_e ARB_MODE    = ARB_RR,
  localparam int       PW          = NUM_WRITERS > 1 ? $clog2(NUM_WRITERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_WRITERS-1:0] req,
  output logic [NUM_WRITERS-1:0] grant,
  output logic [PW-1:0]          gnt_idx
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_start;
  assign w_start = (ARB_MODE == ARB_RR) ? r_ptr : '0;
  // scan downward so the requester closest to the start position is assigned last
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    for (int k = NUM_WRITERS - 1; k >= 0; k--) begin
      if (req[(int'(w_start) + k) % NUM_WRITERS]) begin
        gnt_idx = PW'((int'(w_start) + k) % NUM_WRITERS);
        grant   = NUM_WRITERS'(1) << ((int'(w_start) + k) % NUM_WRITERS);
      end
    end
    if (rst) grant = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (ARB_MODE == ARB_RR && |req)
      r_ptr <= (gnt_idx == PW'(NUM_WRITERS - 1)) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: multi-port shared register with arbitrated writes and collision counting
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int          NUM_WRITERS = 2,
  parameter int          DATA_W      = 8,
  parameter arb_mode_e   ARB_MODE    = ARB_RR,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int          CNT_W       = 8,
  localparam int         LW          = NUM_WRITERS > 1 ? $clog2(NUM_WRITERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_WRITERS-1:0]        wr_req,
  input  logic [NUM_WRITERS*DATA_W-1:0] wr_data,
  output logic [NUM_WRITERS-1:0]        wr_grant,
  output logic [DATA_W-1:0]             data_out,
  output logic [LW-1:0]                 last_writer,
  output logic                          upd,
  output logic                          collision,
  output logic [CNT_W-1:0]              collision_cnt
);
  logic [LW-1:0] w_idx;
  logic          w_coll;
  assign w_coll = popcount(MAX_WRITERS'(wr_req)) > 1;
  rr_arbiter #(.NUM_WRITERS(NUM_WRITERS), .ARB_MODE(ARB_MODE)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .grant   (wr_grant),
    .gnt_idx (w_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out      <= RESET_VAL;
      last_writer   <= '0;
      upd           <= 1'b0;
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else begin
      upd       <= |wr_req;
      collision <= w_coll;
      if (|wr_req) begin
        data_out    <= wr_data[w_idx*DATA_W +: DATA_W];
        last_writer <= w_idx;
      end
      if (w_coll && !(&collision_cnt)) collision_cnt <= collision_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: three configurations checked against a cycle-level reference model
module tb_shared_reg_arbiter;
  import shared_reg_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [1:0] req_a, req_b, gnt_a, gnt_b;
  logic [3:0] req_c, gnt_c;
  logic [15:0] wd_a, wd_b;
  logic [31:0] wd_c;
  logic [7:0] do_a, do_b, do_c, cnt_a, cnt_b;
  logic lw_a, lw_b, upd_a, upd_b, upd_c, col_a, col_b, col_c;
  logic [1:0] lw_c, cnt_c;
  shared_reg_arbiter #(.NUM_WRITERS(2), .DATA_W(8), .ARB_MODE(ARB_FIXED), .RESET_VAL(8'hA5), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .wr_req(req_a), .wr_data(wd_a), .wr_grant(gnt_a), .data_out(do_a),
    .last_writer(lw_a), .upd(upd_a), .collision(col_a), .collision_cnt(cnt_a));
  shared_reg_arbiter #(.NUM_WRITERS(2), .DATA_W(8), .ARB_MODE(ARB_RR), .RESET_VAL(8'h00), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .wr_req(req_b), .wr_data(wd_b), .wr_grant(gnt_b), .data_out(do_b),
    .last_writer(lw_b), .upd(upd_b), .collision(col_b), .collision_cnt(cnt_b));
  shared_reg_arbiter #(.NUM_WRITERS(4), .DATA_W(8), .ARB_MODE(ARB_RR), .RESET_VAL(8'h00), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .wr_req(req_c), .wr_data(wd_c), .wr_grant(gnt_c), .data_out(do_c),
    .last_writer(lw_c), .upd(upd_c), .collision(col_c), .collision_cnt(cnt_c));
  int errors = 0, checks = 0;
  int nw[3] = '{2, 2, 4};
  int rr[3] = '{0, 1, 1};
  int cmax[3] = '{255, 255, 3};
  int rv[3] = '{'hA5, 0, 0};
  int s_req[3];
  int s_dat[3][4];
  int m_data[3], m_last[3], m_upd[3], m_coll[3], m_cnt[3], m_ptr[3], mw[3];
  string fn[5] = '{"data_out", "last_writer", "upd", "collision", "collision_cnt"};
  function automatic int mwin(int i);
    int start;
    if (rst) return -1;
    start = rr[i] ? m_ptr[i] : 0;
    for (int k = 0; k < nw[i]; k++)
      if (s_req[i][(start + k) % nw[i]]) return (start + k) % nw[i];
    return -1;
  endfunction
  task automatic drive();
    logic [31:0] g[3];
    int e;
    @(negedge clk);
    req_a = s_req[0][1:0];
    req_b = s_req[1][1:0];
    req_c = s_req[2][3:0];
    wd_a = {s_dat[0][1][7:0], s_dat[0][0][7:0]};
    wd_b = {s_dat[1][1][7:0], s_dat[1][0][7:0]};
    wd_c = {s_dat[2][3][7:0], s_dat[2][2][7:0], s_dat[2][1][7:0], s_dat[2][0][7:0]};
    #1;
    g = '{32'(gnt_a), 32'(gnt_b), 32'(gnt_c)};
    for (int i = 0; i < 3; i++) begin
      mw[i] = mwin(i);
      e = mw[i] < 0 ? 0 : 1 << mw[i];
      checks++;
      if (g[i] !== 32'(e)) begin
        errors++;
        $display("FAIL grant dut%0d: got %0h expected %0h", i, g[i], e);
      end
    end
  endtask
  task automatic tick();
    logic [31:0] g[3][5];
    int e[3][5];
    int pc;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_data[i] = rv[i]; m_last[i] = 0; m_upd[i] = 0; m_coll[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
      end else begin
        pc = $countones(s_req[i]);
        m_upd[i] = mw[i] >= 0 ? 1 : 0;
        if (mw[i] >= 0) begin
          m_data[i] = s_dat[i][mw[i]];
          m_last[i] = mw[i];
          if (rr[i] != 0) m_ptr[i] = (mw[i] + 1) % nw[i];
        end
        m_coll[i] = pc > 1 ? 1 : 0;
        if (pc > 1 && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
    end
    #1;
    g[0] = '{32'(do_a), 32'(lw_a), 32'(upd_a), 32'(col_a), 32'(cnt_a)};
    g[1] = '{32'(do_b), 32'(lw_b), 32'(upd_b), 32'(col_b), 32'(cnt_b)};
    g[2] = '{32'(do_c), 32'(lw_c), 32'(upd_c), 32'(col_c), 32'(cnt_c)};
    for (int i = 0; i < 3; i++) begin
      e[i] = '{m_data[i], m_last[i], m_upd[i], m_coll[i], m_cnt[i]};
      for (int f = 0; f < 5; f++) begin
        checks++;
        if (g[i][f] !== 32'(e[i][f])) begin
          errors++;
          $display("FAIL %s dut%0d: got %0h expected %0h", fn[f], i, g[i][f], e[i][f]);
        end
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    s_req = '{3, 3, 15};
    for (int i = 0; i < 3; i++) for (int p = 0; p < 4; p++) s_dat[i][p] = int'($urandom_range(0, 255));
    repeat (2) begin drive(); tick(); end
    checks++;
    if (do_a !== 8'hA5 || gnt_a !== 2'b00 || cnt_a !== 8'd0 || upd_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%h grant=%b cnt=%0d upd=%b expected A5/00/0/0", do_a, gnt_a, cnt_a, upd_a);
    end
    rst = 1'b0;
  endtask
  task automatic test_fixed();
    s_req = '{3, 0, 0};
    s_dat[0][0] = 'h11;
    s_dat[0][1] = 'h22;
    repeat (3) begin
      drive();
      checks++;
      if (gnt_a !== 2'b01) begin errors++; $display("FAIL fixed_grant: got %b expected 01", gnt_a); end
      tick();
    end
    checks++;
    if (do_a !== 8'h11 || col_a !== 1'b1 || cnt_a !== 8'd3) begin
      errors++;
      $display("FAIL fixed_result: got data=%h coll=%b cnt=%0d expected 11/1/3", do_a, col_a, cnt_a);
    end
  endtask
  task automatic test_rr_alternate();
    s_req = '{0, 3, 0};
    s_dat[1][0] = 'h11;
    s_dat[1][1] = 'h22;
    for (int k = 0; k < 4; k++) begin
      drive();
      tick();
      checks++;
      if (do_b !== ((k % 2) != 0 ? 8'h22 : 8'h11) || upd_b !== 1'b1) begin
        errors++;
        $display("FAIL rr_alternate step %0d: got data=%h upd=%b", k, do_b, upd_b);
      end
    end
  endtask
  task automatic test_wrap();
    s_req = '{0, 0, 4};
    drive(); tick();
    s_req[2] = 5;
    drive();
    checks++;
    if (gnt_c !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b expected 0001", gnt_c); end
    tick();
    drive();
    checks++;
    if (gnt_c !== 4'b0100) begin errors++; $display("FAIL after_wrap_grant: got %b expected 0100", gnt_c); end
    tick();
  endtask
  task automatic test_saturate();
    rst = 1'b1;
    s_req = '{0, 0, 0};
    drive(); tick();
    rst = 1'b0;
    s_req[2] = 15;
    repeat (5) begin drive(); tick(); end
    checks++;
    if (cnt_c !== 2'd3) begin errors++; $display("FAIL saturate: got %0d expected 3", cnt_c); end
  endtask
  task automatic test_reset_with_write();
    s_req = '{2, 3, 15};
    drive(); tick();
    rst = 1'b1;
    s_req = '{2, 3, 15};
    drive(); tick();
    checks++;
    if (do_a !== 8'hA5 || lw_a !== 1'b0 || upd_a !== 1'b0 || cnt_a !== 8'd0 || cnt_c !== 2'd0) begin
      errors++;
      $display("FAIL reset_with_write: got data=%h last=%b upd=%b cnt=%0d/%0d", do_a, lw_a, upd_a, cnt_a, cnt_c);
    end
    rst = 1'b0;
  endtask
  task automatic test_random();
    repeat (300) begin
      rst = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < 3; i++) begin
        s_req[i] = int'($urandom) & ((1 << nw[i]) - 1);
        for (int p = 0; p < 4; p++) s_dat[i][p] = int'($urandom_range(0, 255));
      end
      drive();
      tick();
    end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_fixed();
    test_rr_alternate();
    test_wrap();
    test_saturate();
    test_reset_with_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
